// File: rtl/dac_spi_if.sv
// dac_spi_if: sample handshake from the upstream ADC stage plus the
// serial lines and status flags of the LTC2624 DAC frame sender.
// master = upstream / host side, slave = dac_spi.
interface dac_spi_if;
  logic [0:11] datos;
  logic        ready;
  logic        dac_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    output datos, ready,
    input  dac_cs_n, spi_sck, spi_mosi, busy, done, overrun
  );

  modport slave (
    input  datos, ready,
    output dac_cs_n, spi_sck, spi_mosi, busy, done, overrun
  );
endinterface

// File: rtl/dac_spi.sv
// dac_spi: sends each new ADC sample to an LTC2624 DAC as a 32-bit
// write-and-update SPI frame (mode 0, MSB first).
// A one-deep pending register decouples the upstream ready edges from
// the frame timing; a sample that arrives while another is still pending
// replaces it and pulses overrun.
// Optional build macro DAC_SPI_OFFSET_BINARY_EN: flips the sample MSB on
// capture, converting two's complement input to offset binary.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame in flight, dac_cs_n high, waiting for a pending sample
// SHIFT | dac_cs_n low, 32 SCK periods of CLK_DIV low + CLK_DIV high
// GAP   | dac_cs_n high for CLK_DIV cycles between frames
module dac_spi #(
  parameter int          CLK_DIV  = 2,
  parameter logic [3:0]  DAC_ADDR = 4'hF
) (
  input  logic     clock,
  input  logic     reset_n,
  dac_spi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [3:0] CMD_WRUP = 4'b0011;

  state_t      state, state_nxt;
  logic        ready_q, armed, rdy_edge;
  logic        pend_full;
  logic [11:0] pend_data, sample_in;
  logic [31:0] shreg, frame;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic        cs_n_q, sck_q, mosi_q, done_q, ovr_q;
  logic        div_tc, load, sck_rise, sck_fall, frame_end;

  // armed blocks a ready that is already high out of reset from counting as an edge
  assign rdy_edge = bus.ready & ~ready_q & armed;
  assign div_tc   = (div_cnt == 8'd0);
  assign frame    = {8'h00, CMD_WRUP, DAC_ADDR, pend_data, 4'h0};

  // sample conditioning on capture
  always_comb begin
    sample_in = bus.datos;
`ifdef DAC_SPI_OFFSET_BINARY_EN
    sample_in[11] = ~sample_in[11];
`endif
  end

  // ready edge detector and one-deep pending sample register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      armed     <= 1'b0;
      pend_full <= 1'b0;
      pend_data <= 12'h000;
      ovr_q     <= 1'b0;
    end else begin
      ready_q <= bus.ready;
      if (!bus.ready) armed <= 1'b1;
      // a load in the same cycle empties the slot, so the new sample is not an overrun
      ovr_q <= rdy_edge & pend_full & ~load;
      if (rdy_edge) begin
        pend_full <= 1'b1;
        pend_data <= sample_in;
      end else if (load) begin
        pend_full <= 1'b0;
      end
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sck_rise  = 1'b0;
    sck_fall  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (pend_full) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (div_tc) begin
          if (!sck_q) begin
            sck_rise = 1'b1;
          end else if (bit_cnt == 5'd0) begin
            frame_end = 1'b1;
            state_nxt = GAP;
          end else begin
            sck_fall = 1'b1;
          end
        end
      end
      GAP: begin
        if (div_tc) begin
          if (pend_full) begin
            load      = 1'b1;
            state_nxt = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // shift register, half-period and bit down-counters, registered SPI outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= 32'h0;
      div_cnt <= 8'd0;
      bit_cnt <= 5'd0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (load) begin
        shreg   <= frame;
        div_cnt <= DIV_LOAD;
        bit_cnt <= 5'd31;
        cs_n_q  <= 1'b0;
        sck_q   <= 1'b0;
        mosi_q  <= frame[31];
      end else if (sck_rise) begin
        div_cnt <= DIV_LOAD;
        sck_q   <= 1'b1;
      end else if (sck_fall) begin
        shreg   <= {shreg[30:0], 1'b0};
        div_cnt <= DIV_LOAD;
        bit_cnt <= bit_cnt - 5'd1;
        sck_q   <= 1'b0;
        mosi_q  <= shreg[30];
      end else if (frame_end) begin
        div_cnt <= DIV_LOAD;
        cs_n_q  <= 1'b1;
        sck_q   <= 1'b0;
        mosi_q  <= 1'b0;
      end else if (state != IDLE && !div_tc) begin
        div_cnt <= div_cnt - 8'd1;
      end
    end
  end

  assign bus.dac_cs_n = cs_n_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.done     = done_q;
  assign bus.overrun  = ovr_q;
  assign bus.busy     = (state != IDLE) | pend_full;

endmodule

// File: doc/dac_spi.md
DAC_SPI -- requirements
Module: dac_spi

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SCK half-period in clock cycles, legal range 1..255.
REQ-002 SHALL have parameter DAC_ADDR, default 4'hF: LTC2624 address nibble (4'hF = all channels).
REQ-003 SHALL have port clock  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port datos  input  [0:11]: sample from the upstream adc stage; datos[0] is the MSB.
REQ-006 SHALL have port ready  input  1: upstream sample-valid level, held high for one or more cycles per sample.
REQ-007 SHALL have port dac_cs_n  output  1: DAC chip select, active low.
REQ-008 SHALL have port spi_sck  output  1: serial clock to the DAC.
REQ-009 SHALL have port spi_mosi  output  1: serial data to the DAC, MSB first.
REQ-010 SHALL have port busy  output  1: high while a frame is in flight or pending.
REQ-011 SHALL have port done  output  1: one-cycle pulse at frame completion.
REQ-012 SHALL have port overrun  output  1: one-cycle pulse when a pending sample is overwritten.

Function
REQ-013 SHALL treat a sample as offered only on a rising edge of ready, using a registered copy of ready.
- A held-high ready SHALL NOT cause a second offer.
REQ-014 SHALL capture datos into a one-deep pending register in the edge-detect cycle.
- If the pending register is already full, it SHALL be overwritten and overrun SHALL pulse.
REQ-015 SHALL build each frame as 32 bits, sent MSB first, in this order:
- 8'h00, then command 4'b0011 (write and update), then DAC_ADDR, then the 12-bit sample, then 4'h0.
REQ-016 SHALL use a state machine with states IDLE, SHIFT and GAP.
- IDLE -> SHIFT when the pending register is full: load the shift register, clear pending, drive dac_cs_n=0, present bit 31 on spi_mosi.
- SHIFT: spi_sck SHALL stay low for CLK_DIV cycles, then high for CLK_DIV cycles, 32 times.
- spi_mosi SHALL change only on the cycle spi_sck falls, so the DAC samples it on the rising edge.
- SHIFT -> GAP after the 32nd SCK high phase: dac_cs_n=1, spi_sck=0, done pulses for one cycle.
- GAP: dac_cs_n SHALL stay high for CLK_DIV cycles, then go to IDLE, or straight to SHIFT if a sample is pending.
REQ-017 SHALL keep each frame at exactly 64*CLK_DIV cycles of dac_cs_n low.
REQ-018 SHALL start a frame (dac_cs_n low) one cycle after the ready rising edge when in IDLE.
REQ-019 SHALL drive busy high when the state is not IDLE or the pending register is full.
REQ-020 SHALL accept and capture a sample arriving during SHIFT or GAP without disturbing the frame in flight.
REQ-021 SHALL, when a ready edge and an IDLE->SHIFT load fall in the same cycle, send the older sample and hold the new one as pending.
REQ-022 SHALL drive spi_sck low and spi_mosi at 0 whenever dac_cs_n is high.

Reset
REQ-023 SHALL, while reset_n=0, force: state IDLE, pending empty, dac_cs_n=1, spi_sck=0, spi_mosi=0, busy=0, done=0, overrun=0, registered ready=0.
REQ-024 SHALL abort any frame in progress when reset is asserted mid-frame.
- dac_cs_n SHALL go high asynchronously.
- No done pulse SHALL be issued for the aborted frame.
REQ-025 SHALL NOT treat ready already high at reset release as a rising edge until after ready has first been seen low.

Configuration
REQ-026 SHALL, when the macro DAC_SPI_OFFSET_BINARY_EN is defined, invert datos[0] on capture (two's complement to offset binary).
- Without the macro, datos SHALL be sent unmodified.

Verification
REQ-027 Reset, then datos=12'hABC with one ready pulse, CLK_DIV=2 -> dac_cs_n low 128 cycles, 32 SCK rises, MOSI word 32'h003FABC0, one done pulse.
REQ-028 ready held high for 200 cycles with datos=12'h123 -> exactly one frame, word 32'h003F1230.
REQ-029 Three ready edges 20 cycles apart (12'h001, 12'h002, 12'h003) -> frames carry 12'h001 then 12'h003, one overrun pulse, no frame for 12'h002.
REQ-030 reset_n low at cycle 50 of a frame -> dac_cs_n=1 and spi_sck=0 immediately, no done pulse, busy=0; next sample sent as a normal full frame.
REQ-031 DAC_SPI_OFFSET_BINARY_EN defined, datos=12'h800 -> data field 12'h000; datos=12'h7FF -> data field 12'hFFF.
REQ-032 Back-to-back: second ready edge during SHIFT -> dac_cs_n high for exactly CLK_DIV cycles between frames; busy stays high throughout.
